// File: rtl/boot_loader_if.sv
// Source-byte handshake, boot-memory bus and status signals of the boot loader.
// The slave modport is the loader; the master modport is the source/memory side.
interface boot_loader_if;
    logic       Start;
    logic       InValid;
    logic [7:0] InData;
    logic       InReady;
    logic       BootLoad;
    logic [3:0] BootLoadAddress;
    logic [7:0] WriteToMemory;
    logic [7:0] ReadFromMemory;
    logic       Done;
    logic       Error;
    logic [7:0] Checksum;

    modport master (
        output Start, InValid, InData, ReadFromMemory,
        input  InReady, BootLoad, BootLoadAddress, WriteToMemory, Done, Error, Checksum
    );

    modport slave (
        input  Start, InValid, InData, ReadFromMemory,
        output InReady, BootLoad, BootLoadAddress, WriteToMemory, Done, Error, Checksum
    );
endinterface

// File: rtl/boot_loader.sv
// Loads 8 program bytes into boot memory (addresses 0..7), then reads them back
// and compares the readback sum against the running checksum of accepted bytes.
module boot_loader (
    input  logic         clk,
    input  logic         nReset,
    boot_loader_if.slave bus
);
    typedef enum logic [2:0] {StIdle, StLoad, StFlush, StVerify, StDone, StError} stateT;

    stateT       stateQ, stateD;
    logic [2:0]  countQ, countD;
    logic [7:0]  idleQ, idleD;
    logic [3:0]  verCntQ, verCntD;
    logic [7:0]  verSumQ, verSumD;
    logic [3:0]  addrQ, addrD;
    logic [7:0]  dataQ, dataD;
    logic [7:0]  sumQ, sumD;
    logic        handshake;

    assign handshake = bus.InValid && (stateQ == StLoad);

    always_comb begin
        stateD  = stateQ;
        countD  = countQ;
        idleD   = idleQ;
        verCntD = verCntQ;
        verSumD = verSumQ;
        addrD   = addrQ;
        dataD   = dataQ;
        sumD    = sumQ;
        case (stateQ)
            StIdle, StDone, StError: begin
                if (bus.Start) begin
                    stateD  = StLoad;
                    countD  = 3'd0;
                    idleD   = 8'd0;
                    verCntD = 4'd0;
                    verSumD = 8'd0;
                    sumD    = 8'd0;
                end
            end
            StLoad: begin
                if (handshake) begin
                    dataD  = bus.InData;
                    addrD  = {1'b0, countQ};
                    sumD   = sumQ + bus.InData;
                    countD = countQ + 3'd1;
                    idleD  = 8'd0;
                    if (countQ == 3'd7) begin
                        stateD = StFlush;
                    end
                end else begin
                    idleD = idleQ + 8'd1;
                    if (idleQ == 8'd254) begin
                        stateD = StError;
                    end
                end
            end
            StFlush: begin
                // Last byte is written on this cycle's edge; readback starts at address 0.
                stateD  = StVerify;
                addrD   = 4'd0;
                verCntD = 4'd0;
                verSumD = 8'd0;
            end
            StVerify: begin
                verCntD = verCntQ + 4'd1;
                if (verCntQ < 4'd7) begin
                    addrD = addrQ + 4'd1;
                end
                // Readback lags the address by one cycle: data for address k arrives at k+1.
                if (verCntQ >= 4'd1 && verCntQ <= 4'd8) begin
                    verSumD = verSumQ + bus.ReadFromMemory;
                end
                if (verCntQ == 4'd9) begin
                    stateD = (verSumQ == sumQ) ? StDone : StError;
                end
            end
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            stateQ  <= StIdle;
            countQ  <= 3'd0;
            idleQ   <= 8'd0;
            verCntQ <= 4'd0;
            verSumQ <= 8'd0;
            addrQ   <= 4'd0;
            dataQ   <= 8'd0;
            sumQ    <= 8'd0;
        end else begin
            stateQ  <= stateD;
            countQ  <= countD;
            idleQ   <= idleD;
            verCntQ <= verCntD;
            verSumQ <= verSumD;
            addrQ   <= addrD;
            dataQ   <= dataD;
            sumQ    <= sumD;
        end
    end

    assign bus.InReady         = (stateQ == StLoad);
    assign bus.BootLoad        = (stateQ == StLoad) || (stateQ == StFlush);
    assign bus.Done            = (stateQ == StDone);
    assign bus.Error           = (stateQ == StError);
    assign bus.BootLoadAddress = addrQ;
    assign bus.WriteToMemory   = dataQ;
    assign bus.Checksum        = sumQ;
endmodule

// File: tb/tb_boot_loader.sv
// Randomized self-checking bench for boot_loader with a 16-byte registered-readback memory
// and a reference model derived from the byte stream (sum, expected memory image, latency).
module tb_boot_loader;
    logic clk = 1'b0;
    logic nReset = 1'b0;
    always #5 clk = ~clk;

    boot_loader_if bus();

    boot_loader dut (
        .clk    (clk),
        .nReset (nReset),
        .bus    (bus)
    );

    logic [7:0] mem [16];
    logic       memClear = 1'b1;
    logic       corrupt = 1'b0;
    int         writes;
    logic       highWrite;
    logic [7:0] acceptedQ [$];

    // Boot memory: write while BootLoad is high, readback registered one cycle.
    always @(posedge clk) begin
        if (memClear) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
            writes             <= 0;
            highWrite          <= 1'b0;
            bus.ReadFromMemory <= 8'h00;
        end else begin
            if (bus.BootLoad) begin
                mem[bus.BootLoadAddress] <= bus.WriteToMemory;
                writes                   <= writes + 1;
                if (bus.BootLoadAddress >= 4'd8) highWrite <= 1'b1;
            end
            bus.ReadFromMemory <= mem[bus.BootLoadAddress] +
                ((corrupt && bus.BootLoadAddress == 4'd3) ? 8'd1 : 8'd0);
        end
        if (bus.InValid && bus.InReady) acceptedQ.push_back(bus.InData);
    end

    int errors = 0;
    int checks = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkVal({tag, ":BootLoad"}, 32'(bus.BootLoad), 0);
        checkVal({tag, ":InReady"}, 32'(bus.InReady), 0);
        checkVal({tag, ":Done"}, 32'(bus.Done), 0);
        checkVal({tag, ":Error"}, 32'(bus.Error), 0);
        checkVal({tag, ":Addr"}, 32'(bus.BootLoadAddress), 0);
        checkVal({tag, ":WData"}, 32'(bus.WriteToMemory), 0);
        checkVal({tag, ":Checksum"}, 32'(bus.Checksum), 0);
    endtask

    task automatic pulseStart();
        @(negedge clk);
        bus.Start = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0;
    endtask

    // gapMode: 0 back-to-back, 1 one idle cycle before each byte, 2 random 0..3 idle cycles.
    task automatic runLoad(input logic [7:0] b [8], input int gapMode, input bit startPulses,
                           input bit corr, input string tag);
        logic [7:0] expChk;
        int         cyc;
        int         g;
        bit         fin;
        expChk = 8'h00;
        corrupt = corr;
        acceptedQ.delete();
        pulseStart();
        checkVal({tag, ":startDone"}, 32'(bus.Done), 0);
        checkVal({tag, ":startError"}, 32'(bus.Error), 0);
        checkVal({tag, ":startChk"}, 32'(bus.Checksum), 0);
        checkVal({tag, ":startReady"}, 32'(bus.InReady), 1);
        for (int i = 0; i < 8; i++) begin
            g = (gapMode == 0) ? 0 : (gapMode == 1) ? 1 : int'($urandom_range(3, 0));
            repeat (g) begin
                bus.InValid = 1'b0;
                bus.InData  = 8'($urandom);
                bus.Start   = startPulses;
                @(negedge clk);
            end
            bus.InValid = 1'b1;
            bus.InData  = b[i];
            bus.Start   = startPulses && ($urandom_range(1, 0) == 1);
            @(negedge clk);
            expChk = expChk + b[i];
        end
        bus.InValid = 1'b0;
        bus.Start   = 1'b0;
        checkVal({tag, ":flushBootLoad"}, 32'(bus.BootLoad), 1);
        checkVal({tag, ":flushReady"}, 32'(bus.InReady), 0);
        cyc = 0;
        fin = 1'b0;
        while (!fin && cyc < 30) begin
            bus.InValid = 1'($urandom);
            bus.InData  = 8'($urandom);
            @(negedge clk);
            cyc++;
            if (bus.Done || bus.Error) fin = 1'b1;
        end
        bus.InValid = 1'b0;
        // One FLUSH cycle plus ten VERIFY cycles after the last handshake.
        checkVal({tag, ":latency"}, 32'(cyc), 11);
        checkVal({tag, ":Checksum"}, 32'(bus.Checksum), 32'(expChk));
        checkVal({tag, ":Done"}, 32'(bus.Done), 32'(!corr));
        checkVal({tag, ":Error"}, 32'(bus.Error), 32'(corr));
        checkVal({tag, ":excl"}, 32'(bus.Done && bus.Error), 0);
        checkVal({tag, ":nAccepted"}, 32'(acceptedQ.size()), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < acceptedQ.size()) checkVal({tag, ":order"}, 32'(acceptedQ[i]), 32'(b[i]));
            checkVal({tag, ":mem"}, 32'(mem[i]), 32'(b[i]));
        end
        checkVal({tag, ":highWrite"}, 32'(highWrite), 0);
        corrupt = 1'b0;
    endtask

    logic [7:0] bytes [8];
    int         w0;

    initial begin
        bus.Start   = 1'b0;
        bus.InValid = 1'b0;
        bus.InData  = 8'h00;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        memClear = 1'b0;
        nReset   = 1'b1;
        repeat (5) @(negedge clk);
        checkVal("postReset:BootLoad", 32'(bus.BootLoad), 0);
        checkVal("postReset:writes", 32'(writes), 0);

        // Sequential bytes 01..08.
        for (int i = 0; i < 8; i++) bytes[i] = 8'(i + 1);
        runLoad(bytes, 0, 1'b0, 1'b0, "seq");
        checkVal("seq:chk24", 32'(bus.Checksum), 32'h24);

        // Checksum wrap to zero.
        bytes = '{8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        runLoad(bytes, 0, 1'b0, 1'b0, "wrap");
        checkVal("wrap:chk00", 32'(bus.Checksum), 32'h00);

        // Readback corruption at address 3.
        foreach (bytes[i]) bytes[i] = 8'($urandom);
        runLoad(bytes, 2, 1'b0, 1'b1, "corrupt");

        // Timeout: 3 bytes then silence.
        pulseStart();
        for (int i = 0; i < 3; i++) begin
            bus.InValid = 1'b1;
            bus.InData  = 8'($urandom);
            @(negedge clk);
        end
        bus.InValid = 1'b0;
        repeat (254) @(negedge clk);
        checkVal("timeout:early", 32'(bus.Error), 0);
        checkVal("timeout:stillLoad", 32'(bus.BootLoad), 1);
        @(negedge clk);
        checkVal("timeout:Error", 32'(bus.Error), 1);
        checkVal("timeout:Done", 32'(bus.Done), 0);
        checkVal("timeout:BootLoad", 32'(bus.BootLoad), 0);

        // Asynchronous reset after 5 bytes.
        pulseStart();
        for (int i = 0; i < 5; i++) begin
            bus.InValid = 1'b1;
            bus.InData  = 8'($urandom_range(255, 1));
            @(negedge clk);
        end
        bus.InValid = 1'b0;
        #2 nReset = 1'b0;
        #1 checkAllZero("midReset");
        @(negedge clk);
        nReset = 1'b1;
        w0 = writes;
        repeat (4) @(negedge clk);
        checkVal("midReset:noWrite", 32'(writes), 32'(w0));
        foreach (bytes[i]) bytes[i] = 8'($urandom);
        runLoad(bytes, 0, 1'b0, 1'b0, "reload");

        // Gapped source with Start pulses during LOAD.
        foreach (bytes[i]) bytes[i] = 8'($urandom);
        runLoad(bytes, 1, 1'b1, 1'b0, "gapped");

        for (int r = 0; r < 6; r++) begin
            foreach (bytes[i]) bytes[i] = 8'($urandom);
            runLoad(bytes, 2, 1'($urandom), 1'($urandom), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/boot_loader.md
BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 SHALL have port nReset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port Start, input, 1 bit: load request, sampled in IDLE, DONE and ERROR only.
REQ-004 SHALL have port InValid, input, 1 bit: source byte valid.
REQ-005 SHALL have port InData, input, 8 bits: source program byte.
REQ-006 SHALL have port InReady, output, 1 bit: loader accepts a byte.
REQ-007 SHALL have port BootLoad, output, 1 bit: places the memory in boot-write mode.
REQ-008 SHALL have port BootLoadAddress, output, 4 bits: memory address for writes and readback.
REQ-009 SHALL have port WriteToMemory, output, 8 bits: memory write data.
REQ-010 SHALL have port ReadFromMemory, input, 8 bits: memory readback, registered by memory with 1-cycle latency from BootLoadAddress.
REQ-011 SHALL have port Done, output, 1 bit: load verified.
REQ-012 SHALL have port Error, output, 1 bit: timeout or checksum mismatch.
REQ-013 SHALL have port Checksum, output, 8 bits: mod-256 sum of accepted bytes.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, FLUSH, VERIFY, DONE, ERROR.
REQ-015 SHALL load exactly 8 bytes to addresses 0..7; addresses 8..15 are memory-cleared data space and never written.
REQ-016 IDLE/DONE/ERROR: Start=1 -> LOAD; load count, Checksum, verify sum, timeout cleared; Done, Error cleared on the same edge.
REQ-017 LOAD: BootLoad=1, InReady=1 (combinational from state); handshake = InValid & InReady at a rising edge.
REQ-018 On handshake: WriteToMemory <= InData, BootLoadAddress <= count, Checksum <= Checksum + InData (mod 256), count <= count + 1.
REQ-019 WriteToMemory/BootLoadAddress SHALL hold until the next handshake; back-to-back handshakes (one per cycle) SHALL be supported.
REQ-020 On the 8th handshake -> FLUSH: one cycle, BootLoad=1, InReady=0, so the last byte is written; then -> VERIFY.
REQ-021 LOAD timeout: 8-bit idle counter cleared on each handshake, incremented otherwise; reaching 255 -> ERROR.
REQ-022 VERIFY: BootLoad=0, InReady=0; BootLoadAddress steps 0..7 on 8 consecutive cycles; ReadFromMemory sampled one cycle after each address and accumulated mod 256.
REQ-023 VERIFY SHALL last exactly 10 cycles; on the final edge: sum == Checksum -> DONE, else -> ERROR.
REQ-024 DONE: Done=1, Error=0; ERROR: Error=1, Done=0; both hold until Start or reset.
REQ-025 Start in LOAD, FLUSH or VERIFY SHALL be ignored.
REQ-026 InValid when InReady=0 SHALL be ignored; no byte consumed.
REQ-027 Done and Error SHALL never both be 1.

Reset
REQ-028 nReset=0 at any time, including mid-LOAD or mid-VERIFY, SHALL immediately force IDLE and all outputs to 0 (BootLoad, InReady, Done, Error, BootLoadAddress, WriteToMemory, Checksum).
REQ-029 After nReset release, no memory write SHALL occur until Start.

Verification
REQ-030 Start, bytes 01..08 back-to-back -> addresses 0..7 written 01..08, Checksum=0x24, FLUSH 1 cycle, VERIFY 10 cycles, Done=1.
REQ-031 Bytes FF,FF,02,00,00,00,00,00 -> Checksum=0x00 (wrap), Done=1.
REQ-032 Memory model corrupts address 3 readback by +1 -> Error=1, Done=0.
REQ-033 3 bytes then InValid=0 for 255 cycles -> Error=1, BootLoad=0.
REQ-034 nReset pulse mid-LOAD after 5 bytes -> all outputs 0 immediately, IDLE; new Start reloads from address 0.
REQ-035 InValid gapped every other cycle, Start pulsed during LOAD -> 8 bytes accepted in order, Start ignored, Done=1.
